// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state type and one-hot helper for the scan decoder.
//   dec_state_e : IDLE / DIRECT / SCAN operating states
//   onehot()    : index -> one-hot vector, sized for up to MAX_WIDTH index bits
package decoder_pkg;
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_e;
    localparam int MAX_WIDTH = 8;
    function automatic logic [2**MAX_WIDTH-1:0] onehot(input logic [MAX_WIDTH-1:0] i);
        return {{(2**MAX_WIDTH-1){1'b0}}, 1'b1} << i;
    endfunction
endpackage

// File: rtl/decoder_scan_onehot.sv
// onehot_decoder: combinational WIDTH-to-2**WIDTH one-hot decoder.
//   idx_i    [WIDTH-1:0]     index to decode (WIDTH <= MAX_WIDTH)
//   onehot_o [2**WIDTH-1:0]  1 << idx_i
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]    idx_i,
    output logic [2**WIDTH-1:0] onehot_o
);
    localparam int N = 2**WIDTH;
    assign onehot_o = N'(onehot(MAX_WIDTH'(idx_i)));
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with DIRECT (handshake) and SCAN (self-stepping) modes.
//   clk, rst_n         clock, async active-low reset
//   en, mode           enable; 0 = DIRECT, 1 = SCAN
//   in_valid/in_ready  DIRECT index handshake, in = index
//   dwell              SCAN hold per position minus one
//   out, out_valid     registered one-hot output and its qualifier
//   idx                index currently driven on out
//   wrap               one-cycle pulse on the last->0 scan step
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**WIDTH-1:0]  out,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     idx,
    output logic                 wrap
);
    localparam int N = 2**WIDTH;
    dec_state_e         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [WIDTH-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d, ready_q, ready_d, wrap_q, wrap_d;
    logic [N-1:0]       out_q, dec;

    onehot_decoder #(.WIDTH(WIDTH)) u_dec (.idx_i(idx_d), .onehot_o(dec));

    always_comb begin
        state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        ready_d = state_d == DIRECT;
        case (state_d)
            IDLE: valid_d = 1'b0;
            DIRECT: begin
                // ready_q is only high while already in DIRECT, so entry never accepts
                if (state_q != DIRECT) valid_d = 1'b0;
                else if (in_valid && ready_q) begin
                    idx_d   = in;
                    valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    dwell_d = dwell;
                end else if (cnt_q == dwell_q) begin
                    // dwell is re-sampled only on a step so a hold is never cut short
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    dwell_d = dwell;
                    wrap_d  = &idx_q;
                end else cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            wrap_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            wrap_q  <= wrap_d;
            out_q   <= valid_d ? dec : '0;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign in_ready  = ready_q;
endmodule
